// File: rtl/memn2n_query_seq.sv
// MemN2N sentence-memory sequencer: arbitrates embedding writes into mem_a, runs a query scan
// and emits latency-aligned weight strobes. Define MEM_WRAP_EN for ring-overwrite mode.
`ifndef BW_MEM_ADDR
`define BW_MEM_ADDR 2
`endif

module memn2n_query_seq #(
  parameter int BW_MEM_ADDR = `BW_MEM_ADDR,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clr,
  input  logic                   done_emb_q,
  input  logic                   wr_req,
  output logic                   en_emb_q,
  output logic                   wr_gnt,
  output logic                   mem_we,
  output logic                   mem_oe,
  output logic [BW_MEM_ADDR-1:0] mem_addr,
  output logic                   w_we,
  output logic [BW_MEM_ADDR-1:0] w_idx,
  output logic [BW_MEM_ADDR:0]   fill,
  output logic                   full,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = BW_MEM_ADDR;
  localparam logic [AW:0] NUM_MEM = {1'b1, {AW{1'b0}}};
  localparam logic [2:0]  DRAIN_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EMB_Q = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] scan_base;
  logic [AW-1:0] base_sel;
  logic [AW:0]   scan_cnt;
  logic [AW:0]   scan_len;
  logic [2:0]    drain_cnt;
  logic          scan_last;
  logic          drain_last;
  logic          scan_enter;
  logic          clr_idle;
  logic          wr_window;

  logic [RD_LAT-1:0]         vld_p;
  logic [RD_LAT-1:0][AW-1:0] idx_p;

  // Ring addressing: the sum wraps naturally at NUM_MEM because NUM_MEM is 2**AW.
  function automatic logic [AW-1:0] ring_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return a + b;
  endfunction

  assign full       = (fill == NUM_MEM);
  assign clr_idle   = (state == S_IDLE) && clr;
  assign scan_enter = (state == S_EMB_Q) && done_emb_q;
  assign scan_last  = (scan_cnt == scan_len - 1'b1);
  assign drain_last = (drain_cnt == DRAIN_LAST);
  assign wr_window  = ((state == S_IDLE) && !clr) || (state == S_EMB_Q);

`ifdef MEM_WRAP_EN
  assign wr_gnt   = !rst && wr_req && wr_window;
  assign base_sel = full ? wr_ptr : '0;
`else
  assign wr_gnt   = !rst && wr_req && wr_window && !full;
  assign base_sel = '0;
`endif

  assign mem_we = wr_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)      state_nxt = S_EMB_Q;
      S_EMB_Q: if (done_emb_q) state_nxt = (fill == '0) ? S_DRAIN : S_SCAN;
      S_SCAN:  if (scan_last)  state_nxt = S_DRAIN;
      S_DRAIN: if (drain_last) state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    en_emb_q = 1'b0;
    mem_oe   = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    mem_addr = wr_ptr;
    case (state)
      S_IDLE:  busy     = 1'b0;
      S_EMB_Q: en_emb_q = 1'b1;
      S_SCAN: begin
        mem_oe   = 1'b1;
        mem_addr = ring_add(scan_base, scan_cnt[AW-1:0]);
      end
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  // Write pointer / fill level: clr beats a concurrent request, fill saturates at NUM_MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (clr_idle) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_gnt) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) fill <= fill + 1'b1;
    end
  end

  // Scan bookkeeping: fill is sampled before any same-edge write increment lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_len  <= '0;
      scan_cnt  <= '0;
      scan_base <= '0;
      drain_cnt <= '0;
    end else begin
      if (scan_enter) begin
        scan_len  <= fill;
        scan_cnt  <= '0;
        scan_base <= base_sel;
      end else if ((state == S_SCAN) && !scan_last) begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : 3'd0;
    end
  end

  // Read-latency pipe p0..p(RD_LAT-1): advances only while scanning or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      idx_p <= '0;
    end else if ((state == S_SCAN) || (state == S_DRAIN)) begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_p[i] <= vld_p[i-1];
        idx_p[i] <= idx_p[i-1];
      end
      vld_p[0] <= mem_oe;
      idx_p[0] <= mem_addr;
    end
  end

  assign w_we  = vld_p[RD_LAT-1];
  assign w_idx = idx_p[RD_LAT-1];

endmodule
